// File: rtl/gem_timing_pkg.sv
// Shared timing definitions for the clock160-domain BX/phase logic.
package gem_timing_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } fsm_state_e;

    localparam int unsigned BX_MAX_DEFAULT = 3563;
    localparam int unsigned BX_W_DEFAULT   = 12;
    localparam int unsigned PHASES_PER_BX  = 4;

endpackage

// File: rtl/bx_counter.sv
// Bunch-crossing counter with deferred BC0 handling.
// The counter only moves on the advance strobe (a locked BX boundary); a BC0 seen at
// any other time is remembered and applied at the next boundary.
module bx_counter
    import gem_timing_pkg::*;
#(
    parameter int unsigned BX_MAX = BX_MAX_DEFAULT,
    parameter int unsigned BX_W   = BX_W_DEFAULT
) (
    input  logic            clock160,
    input  logic            reset_n,
    input  logic            i_adv,
    input  logic            i_bc0,
    output logic [BX_W-1:0] o_bx
);

    localparam logic [BX_W-1:0] BxLast = BX_W'(BX_MAX);

    logic [BX_W-1:0] r_bx;
    logic            r_bc0_pend;

    // BX count and pending-BC0 flag; a BC0 coinciding with the boundary is consumed directly
    always_ff @(posedge clock160 or negedge reset_n) begin
        if (!reset_n) begin
            r_bx       <= '0;
            r_bc0_pend <= 1'b0;
        end else if (i_adv) begin
            r_bc0_pend <= 1'b0;
            if (r_bc0_pend || i_bc0) begin
                r_bx <= '0;
            end else if (r_bx == BxLast) begin
                r_bx <= '0;
            end else begin
                r_bx <= r_bx + 1'b1;
            end
        end else if (i_bc0) begin
            r_bc0_pend <= 1'b1;
        end
    end

    assign o_bx = r_bx;

endmodule

// File: rtl/bx_phase_tracker.sv
// Recovers the 160 MHz sub-cycle within each bunch crossing from the sampled 40 MHz clock,
// tracks lock, flags phase errors and keeps a BC0-aligned BX number.
module bx_phase_tracker
    import gem_timing_pkg::*;
#(
    parameter int unsigned BX_MAX     = BX_MAX_DEFAULT,
    parameter int unsigned BX_W       = BX_W_DEFAULT,
    parameter int unsigned LOCK_COUNT = 8,
    parameter int unsigned ERR_W      = 8
) (
    input  logic             clock160,
    input  logic             reset_n,
    input  logic             clock40_i,
    input  logic             bc0_i,
    output logic [1:0]       phase_o,
    output logic             phase0_o,
    output logic [BX_W-1:0]  bx_o,
    output logic             locked_o,
    output logic             phase_err_o,
    output logic [ERR_W-1:0] err_cnt_o
);

    localparam logic [1:0] PhaseLast = 2'(PHASES_PER_BX - 1);
    // Lock is declared when the incremented count reaches LOCK_COUNT-1.
    localparam logic [7:0] GoodLast  = 8'(LOCK_COUNT - 2);

    logic             r_s1;
    logic             r_s2;
    logic [1:0]       r_phase;
    fsm_state_e       r_state;
    logic [7:0]       r_good_cnt;
    logic             r_locked;
    logic             r_phase_err;
    logic [ERR_W-1:0] r_err_cnt;

    logic             w_edge;
    logic             w_phase_last;
    logic             w_mismatch;
    logic [1:0]       w_phase_d;
    fsm_state_e       w_state_d;
    logic [7:0]       w_good_d;
    logic             w_perr_d;
    logic             w_adv;

    // Two-flop sampler of clock40; the rising edge is seen 1-2 cycles late
    always_ff @(posedge clock160 or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= clock40_i;
            r_s2 <= r_s1;
        end
    end

    assign w_edge       = r_s1 & ~r_s2;
    assign w_phase_last = (r_phase == PhaseLast);
    // A detected edge must coincide with the last sub-cycle, and vice versa.
    assign w_mismatch   = w_edge ^ w_phase_last;

    // Lock FSM next state, phase realignment and BX advance decode
    always_comb begin
        w_state_d = r_state;
        w_good_d  = r_good_cnt;
        w_phase_d = r_phase + 2'd1;
        w_perr_d  = 1'b0;
        w_adv     = 1'b0;
        unique case (r_state)
            UNLOCKED: begin
                if (w_edge) begin
                    w_phase_d = 2'd0;
                    w_good_d  = 8'd0;
                    w_state_d = LOCKING;
                end
            end
            LOCKING: begin
                if (w_edge && w_phase_last) begin
                    w_good_d = r_good_cnt + 8'd1;
                    if (r_good_cnt == GoodLast) begin
                        w_state_d = LOCKED;
                    end
                end else if (w_edge) begin
                    w_phase_d = 2'd0;
                    w_good_d  = 8'd0;
                end else if (w_phase_last) begin
                    w_good_d = 8'd0;
                end
            end
            LOCKED: begin
                if (w_mismatch) begin
                    w_perr_d = 1'b1;
                    if (w_edge) begin
                        w_phase_d = 2'd0;
                        w_good_d  = 8'd0;
                        w_state_d = LOCKING;
                    end else begin
                        w_state_d = UNLOCKED;
                    end
                end else if (w_phase_last) begin
                    // Well-placed edge at the last sub-cycle: a locked BX boundary
                    w_adv = 1'b1;
                end
            end
            default: begin
                w_state_d = UNLOCKED;
            end
        endcase
    end

    // FSM, phase counter, lock flag and error reporting registers
    always_ff @(posedge clock160 or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= UNLOCKED;
            r_phase     <= 2'd0;
            r_good_cnt  <= 8'd0;
            r_locked    <= 1'b0;
            r_phase_err <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_d;
            r_phase     <= w_phase_d;
            r_good_cnt  <= w_good_d;
            r_locked    <= (w_state_d == LOCKED);
            r_phase_err <= w_perr_d;
            if (w_perr_d && (r_err_cnt != {ERR_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    bx_counter #(
        .BX_MAX (BX_MAX),
        .BX_W   (BX_W)
    ) u_bx_counter (
        .clock160 (clock160),
        .reset_n  (reset_n),
        .i_adv    (w_adv),
        .i_bc0    (bc0_i),
        .o_bx     (bx_o)
    );

    assign phase_o     = r_phase;
    assign phase0_o    = (r_phase == 2'd0) & r_locked;
    assign locked_o    = r_locked;
    assign phase_err_o = r_phase_err;
    assign err_cnt_o   = r_err_cnt;

endmodule

// File: tb/tb_bx_phase_tracker.sv
// Directed bench for bx_phase_tracker. One clock160 period is 8 time units; clock40_i is
// produced from a 4-cycle generator driven 1 unit after each clock160 rising edge.
module tb_bx_phase_tracker;

    logic        clock160 = 1'b0;
    logic        reset_n;
    logic        clock40_i;
    logic        bc0_i;
    logic [1:0]  phase_o;
    logic        phase0_o;
    logic [11:0] bx_o;
    logic        locked_o;
    logic        phase_err_o;
    logic [7:0]  err_cnt_o;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    // clock40 generator state
    logic        c40_en;
    logic [1:0]  c40_ph;
    logic        stall_arm;

    typedef struct {
        logic        bc0;
        logic [11:0] exp_bx;
    } vec_t;

    vec_t tbl [29];

    bx_phase_tracker dut (
        .clock160    (clock160),
        .reset_n     (reset_n),
        .clock40_i   (clock40_i),
        .bc0_i       (bc0_i),
        .phase_o     (phase_o),
        .phase0_o    (phase0_o),
        .bx_o        (bx_o),
        .locked_o    (locked_o),
        .phase_err_o (phase_err_o),
        .err_cnt_o   (err_cnt_o)
    );

    always #4 clock160 = ~clock160;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // One clock160 cycle: drive clock40 just after the rising edge, return at the falling edge
    task automatic tick();
        @(posedge clock160);
        #1;
        clock40_i = c40_en & (c40_ph < 2'd2);
        if (stall_arm && (c40_ph == 2'd3)) begin
            stall_arm = 1'b0;
        end else begin
            c40_ph = c40_ph + 2'd1;
        end
        @(negedge clock160);
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_phase"},  32'(phase_o),     32'd0);
        chk({tag, "_phase0"}, 32'(phase0_o),    32'd0);
        chk({tag, "_bx"},     32'(bx_o),        32'd0);
        chk({tag, "_locked"}, 32'(locked_o),    32'd0);
        chk({tag, "_perr"},   32'(phase_err_o), 32'd0);
        chk({tag, "_errcnt"}, 32'(err_cnt_o),   32'd0);
    endtask

    // Release reset on a falling edge and restart clock40 so its first rise follows the next edge
    task automatic release_reset();
        reset_n = 1'b1;
        c40_en  = 1'b1;
        c40_ph  = 2'd0;
        cyc     = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Locked run: BC0 in a phase-1 cycle (deferred), then BC0 on a boundary cycle
        tbl = '{
            '{1'b0, 12'd0}, '{1'b0, 12'd0}, '{1'b0, 12'd0}, '{1'b0, 12'd0},
            '{1'b0, 12'd1}, '{1'b0, 12'd1}, '{1'b0, 12'd1}, '{1'b0, 12'd1},
            '{1'b0, 12'd2}, '{1'b0, 12'd2}, '{1'b0, 12'd2}, '{1'b0, 12'd2},
            '{1'b0, 12'd3}, '{1'b1, 12'd3}, '{1'b0, 12'd3}, '{1'b0, 12'd3},
            '{1'b0, 12'd0}, '{1'b0, 12'd0}, '{1'b0, 12'd0}, '{1'b0, 12'd0},
            '{1'b0, 12'd1}, '{1'b0, 12'd1}, '{1'b0, 12'd1}, '{1'b1, 12'd1},
            '{1'b0, 12'd0}, '{1'b0, 12'd0}, '{1'b0, 12'd0}, '{1'b0, 12'd0},
            '{1'b0, 12'd1}
        };

        reset_n   = 1'b0;
        clock40_i = 1'b0;
        bc0_i     = 1'b0;
        c40_en    = 1'b0;
        c40_ph    = 2'd0;
        stall_arm = 1'b0;

        repeat (3) tick();
        chk_all_zero("reset");
        release_reset();

        // Acquisition: realign on the first edge, lock on the eighth
        run_to(2);
        chk("acq_phase_count", 32'(phase_o), 32'd2);
        run_to(3);
        chk("acq_realign", 32'(phase_o), 32'd0);
        chk("acq_unlocked", 32'(locked_o), 32'd0);
        run_to(30);
        chk("acq_not_yet", 32'(locked_o), 32'd0);
        run_to(31);

        for (int i = 0; i < 29; i++) begin
            chk("tbl_bx",     32'(bx_o),        32'(tbl[i].exp_bx));
            chk("tbl_phase",  32'(phase_o),     32'(i % 4));
            chk("tbl_phase0", 32'(phase0_o),    32'((i % 4) == 0));
            chk("tbl_locked", 32'(locked_o),    32'd1);
            chk("tbl_perr",   32'(phase_err_o), 32'd0);
            bc0_i = tbl[i].bc0;
            tick();
        end

        // BX wrap at the end of the orbit
        run_to(14303);
        chk("wrap_3562", 32'(bx_o), 32'd3562);
        run_to(14307);
        chk("wrap_3563", 32'(bx_o), 32'd3563);
        run_to(14311);
        chk("wrap_0", 32'(bx_o), 32'd0);
        run_to(14315);
        chk("wrap_1", 32'(bx_o), 32'd1);

        // Delay clock40 by one clock160 period
        run_to(14319);
        chk("shift_no_err_yet", 32'(err_cnt_o), 32'd0);
        stall_arm = 1'b1;
        run_to(14322);
        chk("shift_pre_locked", 32'(locked_o), 32'd1);
        chk("shift_pre_perr", 32'(phase_err_o), 32'd0);
        run_to(14323);
        chk("shift_perr", 32'(phase_err_o), 32'd1);
        chk("shift_errcnt", 32'(err_cnt_o), 32'd1);
        chk("shift_unlocked", 32'(locked_o), 32'd0);
        chk("shift_bx_held", 32'(bx_o), 32'd2);
        run_to(14324);
        chk("shift_perr_single", 32'(phase_err_o), 32'd0);
        run_to(14351);
        chk("shift_still_unlocked", 32'(locked_o), 32'd0);
        chk("shift_bx_held_late", 32'(bx_o), 32'd2);
        run_to(14352);
        chk("shift_relocked", 32'(locked_o), 32'd1);
        chk("shift_relock_phase0", 32'(phase0_o), 32'd1);
        run_to(14355);
        chk("shift_bx_pre_adv", 32'(bx_o), 32'd2);
        run_to(14356);
        chk("shift_bx_adv", 32'(bx_o), 32'd3);

        // Hold clock40 low for two BX; BC0 arrives in the very cycle lock is lost
        run_to(14363);
        c40_en = 1'b0;
        run_to(14367);
        chk("hold_pre_locked", 32'(locked_o), 32'd1);
        chk("hold_pre_bx", 32'(bx_o), 32'd5);
        bc0_i = 1'b1;
        tick();
        bc0_i = 1'b0;
        chk("hold_perr", 32'(phase_err_o), 32'd1);
        chk("hold_unlocked", 32'(locked_o), 32'd0);
        chk("hold_errcnt", 32'(err_cnt_o), 32'd2);
        chk("hold_bx_held", 32'(bx_o), 32'd5);
        run_to(14369);
        chk("hold_perr_single", 32'(phase_err_o), 32'd0);
        run_to(14371);
        chk("hold_still_unlocked", 32'(locked_o), 32'd0);
        c40_en = 1'b1;
        run_to(14403);
        chk("hold_not_yet", 32'(locked_o), 32'd0);
        run_to(14404);
        chk("hold_relocked", 32'(locked_o), 32'd1);
        chk("hold_relock_bx", 32'(bx_o), 32'd5);
        run_to(14408);
        chk("hold_pending_bc0", 32'(bx_o), 32'd0);
        run_to(14412);
        chk("hold_bx_1", 32'(bx_o), 32'd1);

        // Asynchronous reset mid-BX with bx_o=100
        run_to(14810);
        chk("pre_rst_bx", 32'(bx_o), 32'd100);
        chk("pre_rst_phase", 32'(phase_o), 32'd2);
        chk("pre_rst_locked", 32'(locked_o), 32'd1);
        #1;
        reset_n = 1'b0;
        c40_en  = 1'b0;
        #1;
        chk_all_zero("async_rst");
        repeat (2) tick();
        release_reset();
        run_to(30);
        chk("post_rst_not_yet", 32'(locked_o), 32'd0);
        run_to(31);
        chk("post_rst_locked", 32'(locked_o), 32'd1);
        chk("post_rst_bx", 32'(bx_o), 32'd0);
        chk("post_rst_errcnt", 32'(err_cnt_o), 32'd0);
        run_to(35);
        chk("post_rst_bx_1", 32'(bx_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
